// File: rtl/noc_endpoint_if.sv
// Packet ingress / response egress bundle between a NoC router and one endpoint.
interface noc_endpoint_if;
  logic [31:0] pkt_in;
  logic        pkt_valid_in;
  logic        pkt_ready_out;
  logic [31:0] resp_out;
  logic        resp_valid_out;
  logic        resp_ready_in;

  modport slave (
    input  pkt_in, pkt_valid_in, resp_ready_in,
    output pkt_ready_out, resp_out, resp_valid_out
  );

  modport master (
    output pkt_in, pkt_valid_in, resp_ready_in,
    input  pkt_ready_out, resp_out, resp_valid_out
  );
endinterface

// File: rtl/noc_endpoint.sv
// NoC endpoint: 4-deep ingress FIFO feeding a write/read executor over a
// 16x10 local register file, returning read responses to the sender.
module noc_endpoint #(
  parameter logic [1:0] MY_X = 2'd0,
  parameter logic [1:0] MY_Y = 2'd0
) (
  input  logic          clk,
  input  logic          rst,
  noc_endpoint_if.slave ep,
  output logic [7:0]    drop_count
);

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned DATA_W    = 10;
  localparam int unsigned PKT_W     = 32;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [1:0]        src_x;
    logic [1:0]        src_y;
    logic [1:0]        dst_x;
    logic [1:0]        dst_y;
    logic [3:0]        addr;
    logic [5:0]        rsvd;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_RESP  = 4'h3;

  logic [PKT_W-1:0]  fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  state_e           state_q, state_d;
  pkt_t             hold_q, hold_d;
  logic [PKT_W-1:0] resp_q, resp_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       drop_q, drop_d;

  logic push, pop, mem_we, matched, unused_rsvd;

  assign ep.pkt_ready_out  = (count_q < CNT_W'(DEPTH));
  assign push              = ep.pkt_valid_in && ep.pkt_ready_out;
  assign ep.resp_out       = resp_q;
  assign ep.resp_valid_out = resp_valid_q;
  assign drop_count        = drop_q;
  assign matched           = (hold_q.dst_x == MY_X) && (hold_q.dst_y == MY_Y);
  // Reserved field is carried through the FIFO but never interpreted.
  assign unused_rsvd       = ^hold_q.rsvd;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ep.pkt_in;
  end

  // Pointer/occupancy bookkeeping; push+pop in one cycle leaves count as is.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[hold_q.addr] <= hold_q.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    drop_d       = drop_q;
    pop          = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = pkt_t'(fifo_q[rd_ptr_q]);
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (!matched || ((hold_q.opcode != OP_WRITE) && (hold_q.opcode != OP_READ))) begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (hold_q.opcode == OP_WRITE) begin
          mem_we = 1'b1;
        end else begin
          // Response is addressed back to the requester.
          resp_d       = {OP_RESP, MY_X, MY_Y, hold_q.src_x, hold_q.src_y,
                          hold_q.addr, 6'b0, mem_q[hold_q.addr]};
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (ep.resp_ready_in) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_noc_endpoint.sv
// Directed bench for noc_endpoint: write/read, addressing, drops, backpressure, reset.
module tb_noc_endpoint;

  logic       clk;
  logic       rst;
  logic [7:0] drop_count;
  int         n_total;
  int         n_bad;
  int         lat;

  noc_endpoint_if ep();

  noc_endpoint #(.MY_X(2'd0), .MY_Y(2'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ep         (ep),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one packet and returns at the negedge after it is taken.
  task automatic push_pkt(input logic [31:0] p);
    int guard;
    guard = 0;
    while (!ep.pkt_ready_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("push_timeout", 32'(ep.pkt_ready_out), 32'd1);
    ep.pkt_in       = p;
    ep.pkt_valid_in = 1'b1;
    @(negedge clk);
    ep.pkt_valid_in = 1'b0;
    ep.pkt_in       = '0;
  endtask

  // Waits (bounded) for a response, checks it, then steps one cycle so it is consumed.
  task automatic get_resp(input string tag, input logic [31:0] exp, output int n);
    n = 0;
    while (!ep.resp_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ep.resp_valid_out) check({tag, "_timeout"}, 32'(ep.resp_valid_out), 32'd1);
    check(tag, ep.resp_out, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_q [5];
    n_total          = 0;
    n_bad            = 0;
    rst              = 1'b0;
    ep.pkt_in        = '0;
    ep.pkt_valid_in  = 1'b0;
    ep.resp_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(ep.resp_valid_out), 32'd0);
    check("rst_resp_out", ep.resp_out, 32'h0);
    check("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ep.pkt_ready_out), 32'd1);

    // Write then read same address, with latency from accept to valid.
    push_pkt(32'h1005_0155);
    repeat (3) @(negedge clk);
    push_pkt(32'h2005_0000);
    get_resp("rd_after_wr", 32'h3005_0155, lat);
    check("rd_latency", 32'(lat), 32'd2);

    push_pkt(32'h2903_0000);
    get_resp("src_swap", 32'h3093_0000, lat);

    // Reserved bits set on input must not leak into stored data.
    push_pkt(32'h100A_FC2A);
    push_pkt(32'h200A_0000);
    get_resp("rsvd_ignored", 32'h300A_002A, lat);

    // Drops: wrong destination and illegal opcodes.
    push_pkt(32'h1045_03FF);
    repeat (4) @(negedge clk);
    check("drop_one", 32'(drop_count), 32'd1);
    push_pkt(32'h2005_0000);
    get_resp("drop_no_write", 32'h3005_0155, lat);
    push_pkt(32'h0000_0000);
    push_pkt(32'h3000_0000);
    repeat (6) @(negedge clk);
    check("drop_bad_op", 32'(drop_count), 32'd3);
    for (int i = 0; i < 251; i++) push_pkt(32'h1045_03FF);
    repeat (12) @(negedge clk);
    check("drop_254", 32'(drop_count), 32'd254);
    push_pkt(32'h1045_03FF);
    repeat (4) @(negedge clk);
    check("drop_255", 32'(drop_count), 32'd255);
    for (int i = 0; i < 50; i++) push_pkt(32'h1045_03FF);
    repeat (12) @(negedge clk);
    check("drop_sat", 32'(drop_count), 32'd255);

    // Backpressure: stalled response, FIFO fills, then drain in order.
    push_pkt(32'h1001_0011);
    push_pkt(32'h1002_0022);
    push_pkt(32'h1003_0033);
    push_pkt(32'h1004_0044);
    repeat (10) @(negedge clk);
    ep.resp_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) push_pkt({12'h200, 4'(i), 16'h0000});
    check("full_ready", 32'(ep.pkt_ready_out), 32'd0);
    check("stall_valid", 32'(ep.resp_valid_out), 32'd1);
    check("stall_resp", ep.resp_out, 32'h3001_0011);
    repeat (5) @(negedge clk);
    check("stall_resp_stable", ep.resp_out, 32'h3001_0011);
    check("full_ready_hold", 32'(ep.pkt_ready_out), 32'd0);
    exp_q = '{32'h3001_0011, 32'h3002_0022, 32'h3003_0033, 32'h3004_0044, 32'h3005_0155};
    ep.resp_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) get_resp($sformatf("drain%0d", i), exp_q[i], lat);
    repeat (6) @(negedge clk);
    check("drain_no_extra", 32'(ep.resp_valid_out), 32'd0);

    // Reset while in RESP with three packets queued.
    ep.resp_ready_in = 1'b0;
    push_pkt(32'h2001_0000);
    push_pkt(32'h2002_0000);
    push_pkt(32'h2003_0000);
    push_pkt(32'h2004_0000);
    @(negedge clk);
    check("pre_rst_valid", 32'(ep.resp_valid_out), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(ep.resp_valid_out), 32'd0);
    check("mid_rst_resp", ep.resp_out, 32'h0);
    check("mid_rst_ready", 32'(ep.pkt_ready_out), 32'd1);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b1;
    ep.resp_ready_in = 1'b1;
    repeat (6) @(negedge clk);
    check("no_stale_resp", 32'(ep.resp_valid_out), 32'd0);
    push_pkt(32'h2001_0000);
    get_resp("mem_cleared1", 32'h3001_0000, lat);
    push_pkt(32'h2005_0000);
    get_resp("mem_cleared5", 32'h3005_0000, lat);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_endpoint.md
NOC_ENDPOINT -- requirements
Module: noc_endpoint

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-low.
REQ-002 Parameter MY_X, default 2'd0, this endpoint's X coordinate.
REQ-003 Parameter MY_Y, default 2'd0, this endpoint's Y coordinate.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 pkt_in  input  32  packet from NoC router ejection port.
REQ-007 pkt_valid_in  input  1  pkt_in valid.
REQ-008 pkt_ready_out  output  1  endpoint can accept pkt_in this cycle.
REQ-009 resp_out  output  32  read-response packet toward NoC injection port.
REQ-010 resp_valid_out  output  1  resp_out valid.
REQ-011 resp_ready_in  input  1  NoC accepts resp_out this cycle.
REQ-012 drop_count  output  8  count of discarded packets.

Function
REQ-013 Packet fields SHALL be: [31:28] opcode (1 write, 2 read, 3 read-response), [27:26] src X, [25:24] src Y, [23:22] dst X, [21:20] dst Y, [19:16] addr, [15:10] reserved, [9:0] data.
REQ-014 Input FIFO: 4 entries x 32 bits; push when pkt_valid_in && pkt_ready_out.
REQ-015 pkt_ready_out SHALL equal (FIFO count < 4); when full it SHALL be 0 even if a pop occurs the same cycle.
REQ-016 Simultaneous push and pop when not full SHALL leave count unchanged and preserve order.
REQ-017 Local memory: 16 x 10-bit registers, indexed by addr.
REQ-018 FSM states IDLE, EXEC, RESP.
REQ-019 IDLE: if FIFO non-empty, pop head into hold register, go EXEC; else stay IDLE.
REQ-020 EXEC, dst X != MY_X or dst Y != MY_Y or opcode not 1/2: increment drop_count (saturating at 255), go IDLE.
REQ-021 EXEC, matched opcode 1: mem[addr] <= data, go IDLE.
REQ-022 EXEC, matched opcode 2: resp_out <= {4'h3, MY_X, MY_Y, src X, src Y, addr, 6'b0, mem[addr]}, resp_valid_out <= 1, go RESP.
REQ-023 RESP: resp_out and resp_valid_out SHALL hold stable until resp_ready_in=1; on that edge resp_valid_out <= 0, go IDLE.
REQ-024 Latency: packet accepted at edge E0 -> popped at E1 -> write committed / resp_valid_out high after E2 (FIFO empty, FSM IDLE at E0).
REQ-025 Packets SHALL execute strictly in arrival order; a read following a write to the same addr SHALL return the written data.
REQ-026 FIFO continues accepting while FSM is in EXEC or RESP, up to full.
REQ-027 Reserved bits [15:10] SHALL be ignored on input.

Reset
REQ-028 While rst=0 on a clock edge: FIFO emptied, state IDLE, resp_out=32'h0, resp_valid_out=0, drop_count=0, all mem entries 10'h0.
REQ-029 pkt_ready_out SHALL be 1 in the first cycle after reset release.
REQ-030 Reset asserted mid-operation (any state, any FIFO level) SHALL discard all pending packets and any un-accepted response.

Verification
REQ-031 MY_X=0,MY_Y=0; write pkt 32'h1005_0155 (addr 5, data 0x155), then read pkt 32'h2005_0000 -> resp_out=32'h3005_0155, valid 2 cycles after read accept.
REQ-032 Read from src (2,1) pkt 32'h2903_0000 after reset -> resp_out=32'h3093_0000 (src/dst swapped, data 0).
REQ-033 Packet with dst X=1 (32'h1045_03FF) -> mem unchanged, drop_count=1; 300 such packets -> drop_count=255.
REQ-034 Hold resp_ready_in=0 while pushing 5 read packets -> pkt_ready_out drops to 0 with 4 in FIFO, resp_out stable; release -> 5 responses in order, none lost.
REQ-035 Assert rst=0 while in RESP with FIFO holding 3 entries -> next cycle resp_valid_out=0, pkt_ready_out=1, drop_count=0, mem reads return 0.
